// File: rtl/orion_soc_types_pkg.sv
// Shared SoC definitions for the memory-mapped UART transmitter: register word
// offsets (addr[3:2]), STATUS bit positions and the transmit FSM state type.
package orion_soc_types;

    localparam logic [1:0] UART_TXDATA_OFF = 2'd0;
    localparam logic [1:0] UART_STATUS_OFF = 2'd1;
    localparam logic [1:0] UART_BAUD_OFF   = 2'd2;
    localparam logic [1:0] UART_CTRL_OFF   = 2'd3;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_LEVEL_LSB = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Small synchronous FIFO with a combinational head read. Pointers and level are
// cleared by reset; storage is not, since stale entries are never visible.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, programmable baud divider and
// a "TX drained" level interrupt. One-cycle response to every request, no stall.
module mmio_uart_tx #(
    parameter int ADDRW        = 32,
    parameter int DATAW        = 32,
    parameter int MASKW        = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int BAUD_DIV_RST = 868
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [ADDRW-1:0] addr_i,
    input  logic [DATAW-1:0] wdata_i,
    input  logic [MASKW-1:0] mask_i,
    input  logic             we_i,
    input  logic             valid_i,
    output logic [DATAW-1:0] rdata_o,
    output logic             resp_o,
    output logic             tx_o,
    output logic             irq_o
);

    import orion_soc_types::*;

    localparam int LVLW = $clog2(FIFO_DEPTH) + 1;

    // A zero divider would stall the bit counter, so it is stored as 1.
    function automatic logic [15:0] merge_baud(input logic [15:0] cur,
                                               input logic [15:0] wd,
                                               input logic [1:0]  be);
        logic [15:0] v;
        v = cur;
        if (be[0]) v[7:0]  = wd[7:0];
        if (be[1]) v[15:8] = wd[15:8];
        if (v == 16'd0) v = 16'd1;
        return v;
    endfunction

    logic [1:0]       off;
    logic             wr_req;
    logic             wr_txdata;
    logic             wr_status;
    logic             wr_baud;
    logic             wr_ctrl;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic [LVLW-1:0]  fifo_level;
    logic             ovf_set;
    logic             ovf_clr;
    logic [15:0]      baud_div;
    logic             irq_en;
    logic             overflow;
    logic             busy;
    logic [DATAW-1:0] status_word;
    logic [DATAW-1:0] rd_word;
    logic             unused_ok;

    uart_tx_state_e   state;
    logic [15:0]      cnt;
    logic [15:0]      baud_lat;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic             line_bit;

    assign unused_ok = ^{addr_i[ADDRW-1:4], addr_i[1:0], wdata_i[DATAW-1:16], mask_i[MASKW-1:2]};

    assign off       = addr_i[3:2];
    assign wr_req    = valid_i & we_i;
    assign wr_txdata = wr_req & (off == UART_TXDATA_OFF) & mask_i[0];
    assign wr_status = wr_req & (off == UART_STATUS_OFF) & mask_i[0];
    assign wr_baud   = wr_req & (off == UART_BAUD_OFF);
    assign wr_ctrl   = wr_req & (off == UART_CTRL_OFF) & mask_i[0];

    // Fullness is judged before the edge, so a same-cycle pop never rescues a push.
    assign fifo_push = wr_txdata & ~fifo_full;
    assign ovf_set   = wr_txdata & fifo_full;
    assign ovf_clr   = wr_status & wdata_i[STAT_OVF_BIT];

    assign busy      = (state != IDLE);
    assign fifo_pop  = ~fifo_empty & ((state == IDLE) | ((state == STOP) & (cnt == 16'd0)));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wdata_i[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        status_word                            = '0;
        status_word[STAT_FULL_BIT]             = fifo_full;
        status_word[STAT_EMPTY_BIT]            = fifo_empty;
        status_word[STAT_BUSY_BIT]             = busy;
        status_word[STAT_OVF_BIT]              = overflow;
        status_word[STAT_LEVEL_LSB +: 8]       = 8'(fifo_level);
    end

    always_comb begin
        rd_word = '0;
        case (off)
            UART_STATUS_OFF: rd_word = status_word;
            UART_BAUD_OFF:   rd_word[15:0] = baud_div;
            UART_CTRL_OFF:   rd_word[0] = irq_en;
            default:         rd_word = '0;
        endcase
    end

    // Bus response stage and control registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_o   <= 1'b0;
            rdata_o  <= '0;
            baud_div <= 16'(BAUD_DIV_RST);
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            resp_o  <= valid_i;
            rdata_o <= (valid_i && !we_i) ? rd_word : '0;
            if (wr_baud) baud_div <= merge_baud(baud_div, wdata_i[15:0], mask_i[1:0]);
            if (wr_ctrl) irq_en <= wdata_i[0];
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            irq_o <= irq_en & fifo_empty & ~busy;
        end
    end

    always_comb begin
        case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shreg[0];
            default: line_bit = 1'b1;
        endcase
    end

    // Frame payload: byte and divider captured on pop, byte shifted per data bit.
    always_ff @(posedge clk_i) begin
        if (fifo_pop) begin
            shreg    <= fifo_rdata;
            baud_lat <= baud_div;
        end else if (state == DATA && cnt == 16'd0) begin
            shreg <= {1'b0, shreg[7:1]};
        end
    end

    // Transmit FSM; tx_o is registered from the current state, one cycle behind it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            tx_o  <= 1'b1;
        end else begin
            tx_o <= line_bit;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= START;
                        cnt   <= baud_div - 16'd1;
                    end
                end
                START: begin
                    if (cnt == 16'd0) begin
                        state <= DATA;
                        cnt   <= baud_lat - 16'd1;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == 16'd0) begin
                        cnt <= baud_lat - 16'd1;
                        if (idx == 3'd7) state <= STOP;
                        else             idx   <= idx + 3'd1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == 16'd0) begin
                        if (!fifo_empty) begin
                            state <= START;
                            cnt   <= baud_div - 16'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
